// File: rtl/bch_syndrome_calc.sv
// ---------------------------------------------------------------------------
// bch_syndrome_calc
//
// Streaming syndrome front end of the BCH decoder. A received codeword comes
// in serially, one bit per accepted beat, highest-degree bit r_(N-1) first.
// 2T Horner accumulators evaluate r(x) at alpha^1..alpha^2T in GF(2^13)
// (field polynomial x^13+x^4+x^3+x+1, alpha = x). A finished codeword is
// copied into an output bank and streamed as S1..S2T, one symbol per beat,
// while the accumulators are free to take the next codeword.
//
// Handshake semantics (both sides): a beat transfers on a rising clk edge
// where valid & ready are both high. A producer holding valid high keeps its
// payload stable until the transfer; ready may change freely. in_start is
// only looked at on a transferring beat.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input bit handshake
//   in_start            marks the first bit of a codeword
//   in_bit              received bit, r_(N-1) first, r_0 last
//   out_valid/out_ready syndrome symbol handshake
//   out_data            syndrome value S_j
//   out_idx             j, 1..2T
//   out_last            high with S_2T
//   out_zero            all 2T syndromes of this codeword are zero
//   busy                accumulation in progress or output bank occupied
//   dbg_state           {output FSM streaming, accumulator FSM state}
// ---------------------------------------------------------------------------
module bch_syndrome_calc #(
    parameter int M = 13,
    parameter int T = 32,
    parameter int N = 8191
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_start,
    input  logic         in_bit,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] out_data,
    output logic [6:0]   out_idx,
    output logic         out_last,
    output logic         out_zero,
    output logic         busy,
    output logic [2:0]   dbg_state
);

    localparam int NS = 2 * T;
    localparam int IW = $clog2(NS);
    // Low-order terms of the field polynomial: x^13 = x^4+x^3+x+1.
    localparam logic [M-1:0] POLY_LOW = M'(27);
    localparam logic [12:0]  CNT_LAST = 13'(N - 1);
    localparam logic         N_IS_ONE = (N == 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} acc_state_t;
    typedef enum logic       {O_IDLE, O_STREAM}        out_state_t;

    acc_state_t   acc_state;
    out_state_t   out_state;
    logic [12:0]  cnt;
    logic [M-1:0] acc      [NS];
    logic [M-1:0] bank     [NS];
    logic [M-1:0] acc_d    [NS];
    logic [M-1:0] load_src [NS];
    logic         load_zero;

    logic accept, fire, last_beat, complete;
    logic last_hs, bank_free, load;

    // Multiply by the constant alpha^e. With e fixed per accumulator this
    // unrolls into a pure XOR network (e repeated shift-and-reduce steps).
    function automatic logic [M-1:0] mul_alpha_pow(input logic [M-1:0] a,
                                                   input int e);
        logic [M-1:0] r;
        r = a;
        for (int k = 0; k < NS; k++) begin
            if (k < e) begin
                r = {r[M-2:0], 1'b0} ^ (r[M-1] ? POLY_LOW : '0);
            end
        end
        return r;
    endfunction

    assign in_ready  = (acc_state != S_HOLD);
    assign out_valid = (out_state == O_STREAM);
    assign busy      = (acc_state != S_IDLE) | out_valid;
    assign dbg_state = {out_valid, acc_state};

    assign accept    = in_valid & in_ready;
    // In IDLE only a start beat begins a codeword; other beats are dropped.
    assign fire      = accept & ((acc_state == S_ACCUM) | in_start);
    assign last_beat = in_start ? N_IS_ONE : (cnt == CNT_LAST);
    assign complete  = fire & last_beat;

    assign last_hs   = out_valid & out_ready & out_last;
    // The bank may be overwritten in the same cycle its final symbol leaves.
    assign bank_free = ~out_valid | last_hs;
    assign load      = (complete & bank_free) | ((acc_state == S_HOLD) & last_hs);

    // Horner step for every j; a start beat restarts from zero so the start
    // bit becomes the leading coefficient. A codeword parked in HOLD is
    // loaded from the registered accumulators, otherwise from the step value
    // so S1 appears the cycle after the last bit.
    always_comb begin
        load_zero = 1'b1;
        for (int j = 0; j < NS; j++) begin
            acc_d[j] = (in_start ? '0 : mul_alpha_pow(acc[j], j + 1))
                       ^ {{(M-1){1'b0}}, in_bit};
            load_src[j] = (acc_state == S_HOLD) ? acc[j] : acc_d[j];
            if (load_src[j] != '0) begin
                load_zero = 1'b0;
            end
        end
    end

    // Accumulator FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_state <= S_IDLE;
            cnt       <= '0;
            for (int j = 0; j < NS; j++) begin
                acc[j] <= '0;
            end
        end else begin
            if (fire) begin
                for (int j = 0; j < NS; j++) begin
                    acc[j] <= acc_d[j];
                end
            end
            case (acc_state)
                S_IDLE, S_ACCUM: begin
                    if (fire) begin
                        if (complete) begin
                            cnt       <= '0;
                            acc_state <= bank_free ? S_IDLE : S_HOLD;
                        end else begin
                            cnt       <= in_start ? 13'd1 : cnt + 13'd1;
                            acc_state <= S_ACCUM;
                        end
                    end
                end
                S_HOLD: begin
                    if (last_hs) begin
                        acc_state <= S_IDLE;
                    end
                end
                default: acc_state <= S_IDLE;
            endcase
        end
    end

    // Output bank and stream FSM. A load takes priority over the end of the
    // previous stream, which gives back-to-back streams with no gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_state <= O_IDLE;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_zero  <= 1'b0;
            for (int j = 0; j < NS; j++) begin
                bank[j] <= '0;
            end
        end else begin
            if (load) begin
                for (int j = 0; j < NS; j++) begin
                    bank[j] <= load_src[j];
                end
                out_state <= O_STREAM;
                out_data  <= load_src[0];
                out_idx   <= 7'd1;
                out_last  <= 1'b0;
                out_zero  <= load_zero;
            end else if (out_valid && out_ready) begin
                if (out_last) begin
                    out_state <= O_IDLE;
                    out_data  <= '0;
                    out_idx   <= '0;
                    out_last  <= 1'b0;
                    out_zero  <= 1'b0;
                end else begin
                    // out_idx is 1-based, so it addresses the next symbol.
                    out_data <= bank[out_idx[IW-1:0]];
                    out_idx  <= out_idx + 7'd1;
                    out_last <= (out_idx == 7'(NS - 1));
                end
            end
        end
    end

endmodule

// File: tb/tb_bch_syndrome_calc.sv
// ---------------------------------------------------------------------------
// tb_bch_syndrome_calc
//
// Self-checking bench for bch_syndrome_calc with a short codeword length.
// Expected syndromes come from a reference model that evaluates
// S_j = sum over set bits r_p of alpha^(p*j) using a table of powers of
// alpha, and are queued per codeword; a monitor compares every output
// handshake against the queue and checks that stalled symbols stay stable.
// ---------------------------------------------------------------------------
module tb_bch_syndrome_calc;

    localparam int M  = 13;
    localparam int T  = 32;
    localparam int N  = 300;
    localparam int NS = 2 * T;
    localparam int W  = 22;              // {data, idx, last, zero}
    localparam int PT = (N - 1) * NS + 1;

    typedef struct {
        int          pos;                // degree of the single set bit, -1 = none
        int          j;
        logic [12:0] syn;
        logic        zero;
    } vec_t;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_start, in_bit;
    logic        out_valid, out_ready, out_last, out_zero, busy;
    logic [12:0] out_data;
    logic [6:0]  out_idx;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    bch_syndrome_calc #(.M(M), .T(T), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_start  (in_start),
        .in_bit    (in_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_zero  (out_zero),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [W-1:0] exp_q[$];
    int          pow_tab [PT];
    logic        cw [N];                 // cw[i] is beat i, i.e. r_(N-1-i)
    logic [12:0] rx_syn [NS+1];
    logic        rx_zero;
    logic        held_valid;
    logic [W-1:0] held_val;
    int          rdy_mode;
    logic        rdy_force;
    vec_t        tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got no event within budget, expected one (t=%0t)", name, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic void build_pow();
        int p;
        p = 1;
        for (int e = 0; e < PT; e++) begin
            pow_tab[e] = p;
            p = p << 1;
            if ((p & 32'h2000) != 0) p = p ^ 32'h201B;
        end
    endfunction

    function automatic void push_expected();
        int          s;
        logic        all_zero;
        logic [12:0] syn [NS+1];
        all_zero = 1'b1;
        for (int j = 1; j <= NS; j++) begin
            s = 0;
            for (int i = 0; i < N; i++) begin
                if (cw[i]) s = s ^ pow_tab[(N - 1 - i) * j];
            end
            syn[j] = s[12:0];
            if (s != 0) all_zero = 1'b0;
        end
        for (int j = 1; j <= NS; j++) begin
            exp_q.push_back({syn[j], 7'(j), logic'(j == NS), all_zero});
        end
    endfunction

    function automatic void set_single(input int pos);
        for (int i = 0; i < N; i++) cw[i] = 1'b0;
        if (pos >= 0) cw[N - 1 - pos] = 1'b1;
    endfunction

    function automatic void fill_random(input int dens);
        for (int i = 0; i < N; i++) cw[i] = ($urandom_range(0, 99) < dens);
    endfunction

    // ---------------- monitor ----------------
    task automatic monitor_step();
        logic [W-1:0] cur, e;
        if (rst_n && out_valid) begin
            cur = {out_data, out_idx, out_last, out_zero};
            if (held_valid) chk("stall_hold", cur, held_val);
            if (out_ready) begin
                held_valid = 1'b0;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_symbol: got idx %0d data 0x%0h, expected no output",
                             out_idx, out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("symbol_idx%0d", e[8:2]), cur, e);
                end
                if (out_idx >= 7'd1 && out_idx <= 7'(NS)) rx_syn[int'(out_idx)] = out_data;
                rx_zero = out_zero;
            end else begin
                held_valid = 1'b1;
                held_val   = cur;
            end
        end else begin
            held_valid = 1'b0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_beat(input logic b, input logic s);
        int t;
        in_valid = 1'b1;
        in_start = s;
        in_bit   = b;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) fail_timeout("in_ready_wait");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_start = 1'b0;
    endtask

    task automatic send_cw(input int gap_pct, input bit chk_lat);
        for (int i = 0; i < N; i++) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                in_start = 1'($urandom_range(0, 1));
                in_bit   = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
            drive_beat(cw[i], i == 0);
        end
        push_expected();
        if (chk_lat) begin
            @(negedge clk);
            chk("latency_valid", out_valid, 1);
            chk("latency_idx", out_idx, 1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || out_valid) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0 || out_valid) fail_timeout("drain");
        @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int          t;
        int          prev;
        int          stale;
        logic [7:0]  pat;

        tbl[0]  = '{-1,  1, 13'h0000, 1'b1};
        tbl[1]  = '{-1, 64, 13'h0000, 1'b1};
        tbl[2]  = '{ 0,  1, 13'h0001, 1'b0};
        tbl[3]  = '{ 0, 37, 13'h0001, 1'b0};
        tbl[4]  = '{ 0, 64, 13'h0001, 1'b0};
        tbl[5]  = '{ 1,  1, 13'h0002, 1'b0};
        tbl[6]  = '{ 1, 12, 13'h1000, 1'b0};
        tbl[7]  = '{ 1, 13, 13'h001B, 1'b0};
        tbl[8]  = '{ 1, 14, 13'h0036, 1'b0};
        tbl[9]  = '{ 2,  7, 13'h0036, 1'b0};
        tbl[10] = '{13,  1, 13'h001B, 1'b0};
        tbl[11] = '{13,  2, 13'h0145, 1'b0};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_start   = 1'b0;
        in_bit     = 1'b0;
        out_ready  = 1'b1;
        rdy_mode   = 0;
        rdy_force  = 1'b1;
        held_valid = 1'b0;
        held_val   = '0;
        rx_zero    = 1'b0;
        for (int k = 0; k <= NS; k++) rx_syn[k] = '0;
        build_pow();

        fork
            forever begin
                @(posedge clk);
                #2;
                if (rdy_mode == 1)      out_ready = ($urandom_range(0, 3) != 0);
                else if (rdy_mode == 2) out_ready = ($urandom_range(0, 7) == 0);
                else                    out_ready = rdy_force;
            end
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("init_in_ready", in_ready, 1);
        chk("init_out_valid", out_valid, 0);
        chk("init_out_data", out_data, 0);
        chk("init_out_idx", out_idx, 0);
        chk("init_out_last", out_last, 0);
        chk("init_out_zero", out_zero, 0);
        chk("init_busy", busy, 0);
        @(posedge clk);
        #1;

        // Fixed single-bit codewords against hand-derived syndromes.
        prev = -2;
        for (int r = 0; r < 12; r++) begin
            if (tbl[r].pos != prev) begin
                set_single(tbl[r].pos);
                send_cw(0, r == 0);
                wait_drain();
                prev = tbl[r].pos;
            end
            chk($sformatf("tbl%0d_S%0d", r, tbl[r].j), rx_syn[tbl[r].j], tbl[r].syn);
            chk($sformatf("tbl%0d_zero", r), rx_zero, tbl[r].zero);
        end

        // Stalled stream, ready toggled 1-0-0-1, second codeword parks in HOLD.
        rdy_force = 1'b0;
        fill_random(50);
        send_cw(0, 0);
        pat = 8'b1001_1001;
        for (int k = 0; k < 8; k++) begin
            rdy_force = pat[7 - k];
            @(posedge clk);
            #1;
        end
        rdy_force = 1'b0;
        fill_random(30);
        send_cw(5, 0);
        @(negedge clk);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_busy", busy, 1);
        repeat (3) @(negedge clk);
        chk("hold_in_ready_later", in_ready, 0);
        @(posedge clk);
        #1;
        rdy_force = 1'b1;
        t = 0;
        @(negedge clk);
        while (!(out_valid && out_ready && out_last) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (out_valid && out_ready && out_last) begin
            chk("last_hs_in_ready", in_ready, 0);
            @(negedge clk);
            chk("gap_in_ready", in_ready, 1);
            chk("gap_out_valid", out_valid, 1);
            chk("gap_out_idx", out_idx, 1);
        end else begin
            fail_timeout("first_stream_last");
        end
        wait_drain();

        // Restart at bit 100, then a full r_1 codeword.
        for (int i = 0; i < 100; i++) drive_beat(1'($urandom_range(0, 1)), i == 0);
        set_single(1);
        send_cw(0, 0);
        wait_drain();
        chk("restart_S1", rx_syn[1], 13'h0002);
        chk("restart_S13", rx_syn[13], 13'h001B);
        chk("restart_zero", rx_zero, 0);

        // Reset in the middle of a stream.
        fill_random(40);
        send_cw(0, 0);
        t = 0;
        @(negedge clk);
        while (!(out_valid && out_idx == 7'd10) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!(out_valid && out_idx == 7'd10)) fail_timeout("reach_idx10");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        held_valid = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_idx", out_idx, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stale = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("post_reset_stale_valid", stale, 0);
        @(posedge clk);
        #1;
        set_single(0);
        send_cw(0, 1);
        wait_drain();
        chk("post_reset_S5", rx_syn[5], 13'h0001);

        // Random codewords, random gaps, random output back-pressure.
        for (int c = 0; c < 8; c++) begin
            rdy_mode = (c % 2) + 1;
            fill_random(int'($urandom_range(1, 60)));
            send_cw(int'($urandom_range(0, 20)), 0);
        end
        wait_drain();
        rdy_mode  = 0;
        rdy_force = 1'b1;
        chk("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
